if_id_fifo: RTL and testbench

- Parametrised successor to the single-entry IF/ID register: a DEPTH-entry instruction queue between fetch and decode, followed by a registered ID output stage.
- Decouples fetch from decode. Fetch keeps filling while ID is stalled. Bubbles (all-zero, invalid) are inserted only when the queue is empty.
- Honours the six-bit pipeline stall vector (bit 1 = IF, bit 2 = ID; 1 = Stop) plus a flush input for branch redirect.

---
 rtl/if_id_fifo.sv | 103 ++++++++++
 tb/tb_if_id_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_fifo.sv
// if_id_fifo: DEPTH-entry fetch queue plus registered ID output stage.
// Define IF_ID_FIFO_STATS_EN to add the hwm occupancy high-water-mark port.
module if_id_fifo #(
   parameter int DEPTH  = 4,
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [PC_W-1:0]   if_pc,
   input  logic [INST_W-1:0] if_inst,
   input  logic              if_valid,
   output logic              if_ready,
   input  logic [5:0]        stall,
   input  logic              flush,
   output logic [PC_W-1:0]   id_pc,
   output logic [INST_W-1:0] id_inst,
   output logic              id_valid,
`ifdef IF_ID_FIFO_STATS_EN
   output logic [CNT_W-1:0]  hwm,
`endif
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [PC_W+INST_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]       rptr;
   logic [PTR_W-1:0]       wptr;
   logic [CNT_W-1:0]       count_nxt;
   logic                   empty;
   logic                   push;
   logic                   adv;
   logic                   pop;
   logic                   bypass;
   logic                   wr;
   logic                   unused_stall;

   assign unused_stall = ^{stall[5:3], stall[0]};

   // Handshake and queue control; if_ready uses the pre-pop count.
   always_comb begin
      empty     = (count == '0);
      if_ready  = (count != FULL);
      push      = if_valid && !stall[1] && if_ready;
      adv       = !stall[2];
      pop       = adv && !empty;
      bypass    = adv && empty && push;
      wr        = push && !bypass;
      count_nxt = count + CNT_W'(wr) - CNT_W'(pop);
   end

   // Queue storage; contents need no reset since count gates reads.
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr)
         mem[wptr] <= {if_pc, if_inst};
   end

   // Pointers, occupancy and the ID output registers.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rptr     <= '0;
         wptr     <= '0;
         count    <= '0;
         id_pc    <= '0;
         id_inst  <= '0;
         id_valid <= 1'b0;
      end else begin
         if (wr)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         count <= count_nxt;
         if (adv) begin
            if (pop) begin
               {id_pc, id_inst} <= mem[rptr];
               id_valid         <= 1'b1;
            end else if (bypass) begin
               id_pc    <= if_pc;
               id_inst  <= if_inst;
               id_valid <= 1'b1;
            end else begin
               id_pc    <= '0;
               id_inst  <= '0;
               id_valid <= 1'b0;
            end
         end
      end
   end

`ifdef IF_ID_FIFO_STATS_EN
   // High-water mark survives flush; flush drives next count to zero.
   always_ff @(posedge clk) begin
      if (rst)
         hwm <= '0;
      else if (!flush && count_nxt > hwm)
         hwm <= count_nxt;
   end
`endif

endmodule

// File: tb/tb_if_id_fifo.sv
// tb_if_id_fifo: directed self-checking bench for if_id_fifo.
// Uses DEPTH = 4 and immediate assertions at every check point.
module tb_if_id_fifo;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        if_valid;
   logic        if_ready;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_valid;
   logic [2:0]  count;
`ifdef IF_ID_FIFO_STATS_EN
   logic [2:0]  hwm;
`endif

   int n_chk;
   int n_fail;

   if_id_fifo #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_valid (if_valid),
      .if_ready (if_ready),
      .stall    (stall),
      .flush    (flush),
      .id_pc    (id_pc),
      .id_inst  (id_inst),
      .id_valid (id_valid),
`ifdef IF_ID_FIFO_STATS_EN
      .hwm      (hwm),
`endif
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      rst      = 1'b1;
      flush    = 1'b0;
      stall    = 6'b0;
      if_valid = 1'b1;
      if_pc    = 32'hdead;
      if_inst  = 32'hbeef;
      tick();
      tick();
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_inst", id_inst, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_if_ready", if_ready, 1);
`ifdef IF_ID_FIFO_STATS_EN
      chk("rst_hwm", hwm, 0);
`endif

      rst     = 1'b0;
      if_pc   = 32'h100;
      if_inst = 32'h24010001;
      tick();
      chk("byp_id_pc", id_pc, 32'h100);
      chk("byp_id_inst", id_inst, 32'h24010001);
      chk("byp_id_valid", id_valid, 1);
      chk("byp_count", count, 0);

      if_valid = 1'b0;
      stall    = 6'b000100;
      tick();
      chk("hold_id_pc", id_pc, 32'h100);
      chk("hold_id_valid", id_valid, 1);

      stall = 6'b0;
      tick();
      chk("bub_id_valid", id_valid, 0);
      chk("bub_id_pc", id_pc, 0);

      stall    = 6'b000010;
      if_valid = 1'b1;
      if_pc    = 32'h180;
      tick();
      chk("ifstall_count", count, 0);
      chk("ifstall_id_valid", id_valid, 0);

      stall = 6'b000100;
      for (int i = 0; i < 5; i++) begin
         if_pc   = 32'h200 + 32'(4 * i);
         if_inst = 32'h1000 + 32'(i);
         tick();
         chk("fill_count", count, (i < 4) ? 64'(i + 1) : 64'd4);
         chk("fill_id_valid", id_valid, 0);
      end
      chk("full_if_ready", if_ready, 0);

      stall   = 6'b0;
      if_pc   = 32'h400;
      if_inst = 32'h4000;
      tick();
      chk("fullpp_id_pc", id_pc, 32'h200);
      chk("fullpp_id_inst", id_inst, 32'h1000);
      chk("fullpp_count", count, 3);
      chk("fullpp_if_ready", if_ready, 1);

      if_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         tick();
         chk("drain_id_pc", id_pc, 32'h200 + 32'(4 * i));
         chk("drain_id_valid", id_valid, 1);
         chk("drain_count", count, 64'(3 - i));
      end
      tick();
      chk("drain_bub_valid", id_valid, 0);
      chk("drain_bub_pc", id_pc, 0);

      stall    = 6'b000100;
      if_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if_pc = 32'h500 + 32'(4 * i);
         tick();
      end
      chk("prefl_count", count, 3);

      flush = 1'b1;
      stall = 6'b0;
      if_pc = 32'h300;
      tick();
      chk("fl_count", count, 0);
      chk("fl_id_valid", id_valid, 0);
      chk("fl_if_ready", if_ready, 1);
      chk("fl_id_pc", id_pc, 0);

      flush    = 1'b0;
      if_valid = 1'b0;
      tick();
      chk("postfl_id_valid", id_valid, 0);
      chk("postfl_id_pc", id_pc, 0);

      if_valid = 1'b1;
      if_pc    = 32'h310;
      tick();
      chk("postfl_byp_pc", id_pc, 32'h310);
      chk("postfl_byp_valid", id_valid, 1);

      stall = 6'b000100;
      if_pc = 32'h600;
      tick();
      chk("wrap_pre_count", count, 1);
      if_pc = 32'h604;
      tick();
      chk("wrap_pre_count", count, 2);
      chk("wrap_hold_pc", id_pc, 32'h310);

      stall = 6'b0;
      for (int i = 2; i < 10; i++) begin
         if_pc = 32'h600 + 32'(4 * i);
         tick();
         chk("wrap_id_pc", id_pc, 32'h600 + 32'(4 * (i - 2)));
         chk("wrap_count", count, 2);
      end
      if_valid = 1'b0;
      tick();
      chk("wrap_tail_pc", id_pc, 32'h620);
      chk("wrap_tail_count", count, 1);
      tick();
      chk("wrap_tail_pc", id_pc, 32'h624);
      chk("wrap_tail_count", count, 0);
      tick();
      chk("wrap_bub_valid", id_valid, 0);
`ifdef IF_ID_FIFO_STATS_EN
      chk("hwm_final", hwm, 4);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
